// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer feeding a first-word-fall-through RX FIFO with RTS flow control.
// Optional UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote of samples 6,7,8 instead of a single sample at 7.
module uart_rx #(
    parameter int DEPTH      = 8,
    parameter int RTS_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_enable_i,
    input  logic        rx_i,
    output logic        rts_n_o,
    input  logic [15:0] baud_div_i,
    input  logic [3:0]  cfg_data_bits_i,
    input  logic        cfg_parity_i,
    input  logic        cfg_dstop_i,
    input  logic        cfg_flow_ctrl_i,
    input  logic        flush_i,
    input  logic        err_clr_i,
    output logic [8:0]  rx_d_o,
    output logic        rx_d_valid_o,
    input  logic        rx_d_ready_i,
    output logic        fifo_full_o,
    output logic        fifo_empty_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overflow_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DSTOP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  sc_q, sc_d;
    logic [3:0]  nbits_q, nbits_d;
    logic        par_en_q, par_en_d;
    logic        dstop_q, dstop_d;
    logic [8:0]  shreg_q, shreg_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic        par_acc_q, par_acc_d;
    logic        perr_q, perr_d;
    logic        rxs, tick, last_tick, sample_evt, sample_bit;
    logic        push, set_perr, set_ferr;
    logic [8:0]  push_word;

    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    rx_d_q, rx_d_d;
    logic          valid_q, valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_err_q, overflow_err_d;
    logic          rts_n_q, rts_n_d;
    logic          full, pop, do_push, do_pop, ovf_set;

    assign rxs       = sync_q[1];
    assign sync_d    = {sync_q[0], rx_i};
    assign tick      = (baud_cnt_q == baud_div_i);
    assign last_tick = tick && (sc_q == 4'd15);
    assign push_word = shreg_q >> (4'd9 - nbits_q);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote6_q, vote6_d, vote7_q, vote7_d;

    assign vote6_d    = (tick && sc_q == 4'd6) ? rxs : vote6_q;
    assign vote7_d    = (tick && sc_q == 4'd7) ? rxs : vote7_q;
    assign sample_evt = tick && (sc_q == 4'd8);
    assign sample_bit = (vote6_q & vote7_q) | (vote6_q & rxs) | (vote7_q & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote6_q <= 1'b1;
            vote7_q <= 1'b1;
        end else begin
            vote6_q <= vote6_d;
            vote7_q <= vote7_d;
        end
    end
`else
    assign sample_evt = tick && (sc_q == 4'd7);
    assign sample_bit = rxs;
`endif

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
        sc_d       = tick ? sc_q + 4'd1 : sc_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        dstop_d    = dstop_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        push       = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs && rx_enable_i) begin
                    state_d    = S_START;
                    baud_cnt_d = '0;
                    sc_d       = '0;
                    nbits_d    = (cfg_data_bits_i >= 4'd5 && cfg_data_bits_i <= 4'd9) ?
                                 cfg_data_bits_i : 4'd8;
                    par_en_d   = cfg_parity_i;
                    dstop_d    = cfg_dstop_i;
                    shreg_d    = '0;
                    bit_idx_d  = '0;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                end
            end
            S_START: begin
                if (sample_evt && sample_bit) state_d = S_IDLE;
                else if (last_tick)           state_d = S_DATA;
            end
            S_DATA: begin
                if (sample_evt) begin
                    shreg_d   = {sample_bit, shreg_q[8:1]};
                    par_acc_d = par_acc_q ^ sample_bit;
                    bit_idx_d = bit_idx_q + 4'd1;
                end
                if (last_tick && bit_idx_q == nbits_q) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (sample_evt) perr_d = (sample_bit != par_acc_q);
                if (last_tick)  state_d = S_STOP;
            end
            S_STOP: begin
                // Leave mid-stop so the next start edge is caught with half a bit of slack.
                if (sample_evt) begin
                    if (!sample_bit)  set_ferr = 1'b1;
                    else if (!perr_q) push     = 1'b1;
                    else              set_perr = 1'b1;
                    state_d   = dstop_q ? S_DSTOP : S_IDLE;
                    bit_idx_d = '0;
                end
            end
            S_DSTOP: begin
                // bit_idx marks that the first stop bit has ended before sampling the second.
                if (last_tick) bit_idx_d = 4'd1;
                if (sample_evt && bit_idx_q == 4'd1) begin
                    if (!sample_bit) set_ferr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop     = valid_q && rx_d_ready_i;
        do_push = push && !flush_i && (!full || pop);
        do_pop  = pop && !flush_i;
        ovf_set = push && !flush_i && full && !pop;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_word;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
        valid_d        = (count_d != '0);
        rx_d_d         = valid_d ? mem_d[rd_ptr_d] : 9'd0;
        parity_err_d   = (parity_err_q & ~err_clr_i) | set_perr;
        frame_err_d    = (frame_err_q & ~err_clr_i) | set_ferr;
        overflow_err_d = (overflow_err_q & ~err_clr_i) | ovf_set;
        rts_n_d        = cfg_flow_ctrl_i && (count_d >= CW'(DEPTH - RTS_MARGIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sync_q         <= 2'b11;
            baud_cnt_q     <= '0;
            sc_q           <= '0;
            nbits_q        <= 4'd8;
            par_en_q       <= 1'b0;
            dstop_q        <= 1'b0;
            shreg_q        <= '0;
            bit_idx_q      <= '0;
            par_acc_q      <= 1'b0;
            perr_q         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rx_d_q         <= '0;
            valid_q        <= 1'b0;
            parity_err_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            overflow_err_q <= 1'b0;
            rts_n_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            baud_cnt_q     <= baud_cnt_d;
            sc_q           <= sc_d;
            nbits_q        <= nbits_d;
            par_en_q       <= par_en_d;
            dstop_q        <= dstop_d;
            shreg_q        <= shreg_d;
            bit_idx_q      <= bit_idx_d;
            par_acc_q      <= par_acc_d;
            perr_q         <= perr_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rx_d_q         <= rx_d_d;
            valid_q        <= valid_d;
            parity_err_q   <= parity_err_d;
            frame_err_q    <= frame_err_d;
            overflow_err_q <= overflow_err_d;
            rts_n_q        <= rts_n_d;
        end
    end

    assign rx_d_o         = rx_d_q;
    assign rx_d_valid_o   = valid_q;
    assign fifo_full_o    = full;
    assign fifo_empty_o   = (count_q == '0);
    assign parity_err_o   = parity_err_q;
    assign frame_err_o    = frame_err_q;
    assign overflow_err_o = overflow_err_q;
    assign rts_n_o        = rts_n_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing formats, parity/frame/overflow errors, RTS, glitch and baud divider.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_enable_i, rx_i, rts_n_o;
    logic [15:0] baud_div_i;
    logic [3:0]  cfg_data_bits_i;
    logic        cfg_parity_i, cfg_dstop_i, cfg_flow_ctrl_i, flush_i, err_clr_i;
    logic [8:0]  rx_d_o;
    logic        rx_d_valid_o, rx_d_ready_i, fifo_full_o, fifo_empty_o;
    logic        parity_err_o, frame_err_o, overflow_err_o;

    int total = 0;
    int bad   = 0;
    int bit_clks = 16;

    uart_rx #(.DEPTH(8), .RTS_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .rx_enable_i(rx_enable_i), .rx_i(rx_i), .rts_n_o(rts_n_o),
        .baud_div_i(baud_div_i), .cfg_data_bits_i(cfg_data_bits_i), .cfg_parity_i(cfg_parity_i),
        .cfg_dstop_i(cfg_dstop_i), .cfg_flow_ctrl_i(cfg_flow_ctrl_i), .flush_i(flush_i),
        .err_clr_i(err_clr_i), .rx_d_o(rx_d_o), .rx_d_valid_o(rx_d_valid_o),
        .rx_d_ready_i(rx_d_ready_i), .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
        .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overflow_err_o(overflow_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic send_body(input logic [8:0] d, input int n, input logic par_en, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par);
    endtask

    task automatic send_frame(input logic [8:0] d, input int n, input logic par_en, input logic par);
        send_body(d, n, par_en, par);
        drive_bit(1'b1);
        if (cfg_dstop_i) drive_bit(1'b1);
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_d_ready_i = 1'b1;
        @(negedge clk);
        rx_d_ready_i = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_d_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_d_valid_o); end
        total++; if (fifo_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", fifo_empty_o); end
        total++; if (fifo_full_o !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", fifo_full_o); end
        total++; if ({parity_err_o, frame_err_o, overflow_err_o} !== 3'b000) begin
            bad++; $display("FAIL reset_errs: got %b want 000", {parity_err_o, frame_err_o, overflow_err_o}); end
        total++; if (rts_n_o !== 1'b1) begin bad++; $display("FAIL reset_rts: got %b want 1", rts_n_o); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int n;
        send_body(9'h0A5, 8, 1'b0, 1'b0);
        rx_i = 1'b1;
        n = 0;
        while (rx_d_valid_o !== 1'b1 && n < 14) begin @(negedge clk); n++; end
        total++; if (rx_d_valid_o !== 1'b1) begin bad++; $display("FAIL 8n1_valid_timing: got %b after %0d clk want 1", rx_d_valid_o, n); end
        total++; if (rx_d_o !== 9'h0A5) begin bad++; $display("FAIL 8n1_data: got %h want 0a5", rx_d_o); end
        total++; if ({parity_err_o, frame_err_o, overflow_err_o} !== 3'b000) begin
            bad++; $display("FAIL 8n1_errs: got %b want 000", {parity_err_o, frame_err_o, overflow_err_o}); end
        repeat (bit_clks) @(negedge clk);
        pop_one();
        total++; if (fifo_empty_o !== 1'b1) begin bad++; $display("FAIL 8n1_pop_empty: got %b want 1", fifo_empty_o); end
    endtask

    task automatic test_7e1();
        cfg_data_bits_i = 4'd7;
        cfg_parity_i    = 1'b1;
        send_frame(9'h053, 7, 1'b1, 1'b0);
        total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h053) begin
            bad++; $display("FAIL 7e1_good: got v=%b d=%h want v=1 d=053", rx_d_valid_o, rx_d_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 7e1_good_perr: got %b want 0", parity_err_o); end
        pop_one();
        send_frame(9'h053, 7, 1'b1, 1'b1);
        total++; if (rx_d_valid_o !== 1'b0) begin bad++; $display("FAIL 7e1_bad_nopush: got %b want 0", rx_d_valid_o); end
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL 7e1_bad_perr: got %b want 1", parity_err_o); end
        clear_errs();
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 7e1_perr_clr: got %b want 0", parity_err_o); end
        cfg_data_bits_i = 4'd8;
        cfg_parity_i    = 1'b0;
    endtask

    task automatic test_9n2();
        cfg_data_bits_i = 4'd9;
        cfg_dstop_i     = 1'b1;
        send_body(9'h1FF, 9, 1'b0, 1'b0);
        drive_bit(1'b1);
        rx_enable_i = 1'b0;
        drive_bit(1'b0);
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
        rx_enable_i = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h1FF) begin
            bad++; $display("FAIL 9n2_data: got v=%b d=%h want v=1 d=1ff", rx_d_valid_o, rx_d_o); end
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL 9n2_ferr: got %b want 1", frame_err_o); end
        clear_errs();
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL 9n2_ferr_clr: got %b want 0", frame_err_o); end
        pop_one();
        total++; if (fifo_empty_o !== 1'b1) begin bad++; $display("FAIL 9n2_single_word: empty=%b want 1", fifo_empty_o); end
        cfg_data_bits_i = 4'd8;
        cfg_dstop_i     = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) send_frame(9'h030 + 9'(i), 8, 1'b0, 1'b0);
        total++; if (fifo_full_o !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", fifo_full_o); end
        total++; if (overflow_err_o !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", overflow_err_o); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h030 + 9'(i)) begin
                bad++; $display("FAIL ovf_order[%0d]: got v=%b d=%h want v=1 d=%h", i, rx_d_valid_o, rx_d_o, 9'h030 + 9'(i)); end
            pop_one();
        end
        total++; if (fifo_empty_o !== 1'b1) begin bad++; $display("FAIL ovf_ninth_lost: empty=%b want 1", fifo_empty_o); end
        clear_errs();
    endtask

    task automatic test_flow();
        cfg_flow_ctrl_i = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send_frame(9'h040 + 9'(i), 8, 1'b0, 1'b0);
        total++; if (rts_n_o !== 1'b0) begin bad++; $display("FAIL rts_5_words: got %b want 0", rts_n_o); end
        send_frame(9'h045, 8, 1'b0, 1'b0);
        total++; if (rts_n_o !== 1'b1) begin bad++; $display("FAIL rts_6_words: got %b want 1", rts_n_o); end
        pop_one();
        repeat (2) @(negedge clk);
        total++; if (rts_n_o !== 1'b0) begin bad++; $display("FAIL rts_after_pop: got %b want 0", rts_n_o); end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
        total++; if (fifo_empty_o !== 1'b1 || rx_d_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush: got empty=%b valid=%b want 1/0", fifo_empty_o, rx_d_valid_o); end
        cfg_flow_ctrl_i = 1'b0;
    endtask

    task automatic test_glitch();
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (rx_d_valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
            bad++; $display("FAIL glitch_nopush: got valid=%b ferr=%b want 0/0", rx_d_valid_o, frame_err_o); end
        send_frame(9'h05A, 8, 1'b0, 1'b0);
        total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h05A) begin
            bad++; $display("FAIL glitch_recover: got v=%b d=%h want v=1 d=05a", rx_d_valid_o, rx_d_o); end
        pop_one();
    endtask

    task automatic test_back_to_back_div3();
        baud_div_i = 16'd3;
        bit_clks   = 64;
        send_frame(9'h0A5, 8, 1'b0, 1'b0);
        send_frame(9'h03C, 8, 1'b0, 1'b0);
        total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h0A5) begin
            bad++; $display("FAIL div3_first: got v=%b d=%h want v=1 d=0a5", rx_d_valid_o, rx_d_o); end
        pop_one();
        total++; if (rx_d_valid_o !== 1'b1 || rx_d_o !== 9'h03C) begin
            bad++; $display("FAIL div3_second: got v=%b d=%h want v=1 d=03c", rx_d_valid_o, rx_d_o); end
        pop_one();
        total++; if ({parity_err_o, frame_err_o, overflow_err_o} !== 3'b000) begin
            bad++; $display("FAIL div3_errs: got %b want 000", {parity_err_o, frame_err_o, overflow_err_o}); end
    endtask

    initial begin
        rx_enable_i     = 1'b1;
        rx_i            = 1'b1;
        baud_div_i      = 16'd0;
        cfg_data_bits_i = 4'd8;
        cfg_parity_i    = 1'b0;
        cfg_dstop_i     = 1'b0;
        cfg_flow_ctrl_i = 1'b0;
        flush_i         = 1'b0;
        err_clr_i       = 1'b0;
        rx_d_ready_i    = 1'b0;
        test_reset();
        test_8n1();
        test_7e1();
        test_9n2();
        test_overflow();
        test_flow();
        test_glitch();
        test_back_to_back_div3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
